mips_single_cycle: RTL and testbench

//  Single-cycle 32-bit MIPS core with byte-addressed, big-endian internal instruction and data memories.
//  - One instruction per clk cycle.
//  - Top-level CPU block; the bench preloads memories and registers through hierarchy.
//  - Required sub-instance names: inst_mem (byte array InstructionMemory), data_mem (byte array data_memory),
//    pc (32-bit reg current_inst), register (array register[0:31]).
//  - Required wire name: instruction (current 32-bit instruction).

---
 rtl/mips_single_cycle.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_mips_single_cycle.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_single_cycle.sv
// -----------------------------------------------------------------------------
// mips_single_cycle
//   Single-cycle 32-bit MIPS core. Each clock edge retires one instruction.
//   Instruction and data memories are byte arrays. They are big-endian and
//   byte-addressed, and addresses wrap modulo their size. Neither memory is
//   cleared by reset, so preloaded contents survive it.
//   Supported instructions: add, sub, and, or, slt, lw, sw, beq, addi and j.
//   Any other encoding behaves as a NOP: PC advances by 4 and no state changes.
//
// Ports
//   clk        in   1   single clock, all state updates on the rising edge
//   reset      in   1   synchronous active-high reset (PC and registers)
//   pc_out     out  32  current program counter
//   instr_out  out  32  instruction fetched at pc_out
//
// Sub-instances
//   pc        (mips_pc)        -> current_inst
//   register  (mips_reg_file)  -> register[0:31]
//   inst_mem  (mips_inst_mem)  -> InstructionMemory[]
//   data_mem  (mips_data_mem)  -> data_memory[]
// -----------------------------------------------------------------------------
module mips_single_cycle #(
    parameter int unsigned IMEM_BYTES = 256,
    parameter int unsigned DMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [31:0] instruction;

    logic [31:0] w_pc;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [25:0] w_target;

    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;

    logic        w_reg_write;
    logic        w_reg_dst_rd;
    logic        w_alu_src_imm;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_jump;
    alu_op_t     w_alu_op;

    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_dm_rdata;
    logic [31:0] w_wb_data;
    logic [4:0]  w_wb_addr;
    logic        w_dm_wr_en;

    // ---------------------------------------------------------------- state
    mips_pc pc (
        .clk       (clk),
        .i_reset   (reset),
        .i_next_pc (w_next_pc),
        .o_pc      (w_pc)
    );

    mips_inst_mem #(.DEPTH(IMEM_BYTES)) inst_mem (
        .clk       (clk),
        .i_wr_en   (1'b0),   // contents are loaded from outside the core
        .i_wr_addr ('0),
        .i_wr_byte ('0),
        .i_addr    (w_pc),
        .o_word    (instruction)
    );

    mips_reg_file register (
        .clk       (clk),
        .i_reset   (reset),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data),
        .i_wr_en   (w_reg_write),
        .i_wr_addr (w_wb_addr),
        .i_wr_data (w_wb_data)
    );

    // A store that coincides with reset must not land in memory.
    assign w_dm_wr_en = w_mem_write & ~reset;

    mips_data_mem #(.DEPTH(DMEM_BYTES)) data_mem (
        .clk       (clk),
        .i_wr_en   (w_dm_wr_en),
        .i_addr    (w_alu_result),
        .i_wr_data (w_rt_data),
        .o_rd_data (w_dm_rdata)
    );

    // --------------------------------------------------------------- decode
    assign w_opcode = instruction[31:26];
    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];
    assign w_rd     = instruction[15:11];
    assign w_funct  = instruction[5:0];
    assign w_simm   = {{16{instruction[15]}}, instruction[15:0]};
    assign w_target = instruction[25:0];

    always_comb begin
        w_reg_write   = 1'b0;
        w_reg_dst_rd  = 1'b0;
        w_alu_src_imm = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_mem_write   = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_alu_op      = ALU_ADD;
        case (w_opcode)
            OP_RTYPE: begin
                w_reg_dst_rd = 1'b1;
                // Only the five listed functs write back; others fall through as NOPs.
                case (w_funct)
                    FN_ADD: begin w_reg_write = 1'b1; w_alu_op = ALU_ADD; end
                    FN_SUB: begin w_reg_write = 1'b1; w_alu_op = ALU_SUB; end
                    FN_AND: begin w_reg_write = 1'b1; w_alu_op = ALU_AND; end
                    FN_OR:  begin w_reg_write = 1'b1; w_alu_op = ALU_OR;  end
                    FN_SLT: begin w_reg_write = 1'b1; w_alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW: begin
                w_reg_write   = 1'b1;
                w_alu_src_imm = 1'b1;
                w_mem_to_reg  = 1'b1;
            end
            OP_SW: begin
                w_alu_src_imm = 1'b1;
                w_mem_write   = 1'b1;
            end
            OP_BEQ:  w_branch = 1'b1;
            OP_ADDI: begin
                w_reg_write   = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            OP_J:    w_jump = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ ALU
    assign w_alu_b = w_alu_src_imm ? w_simm : w_rt_data;

    always_comb begin
        w_alu_result = w_rs_data + w_alu_b;
        case (w_alu_op)
            ALU_ADD: w_alu_result = w_rs_data + w_alu_b;
            ALU_SUB: w_alu_result = w_rs_data - w_alu_b;
            ALU_AND: w_alu_result = w_rs_data & w_alu_b;
            ALU_OR:  w_alu_result = w_rs_data | w_alu_b;
            ALU_SLT: w_alu_result = {31'd0, ($signed(w_rs_data) < $signed(w_alu_b))};
            default: w_alu_result = w_rs_data + w_alu_b;
        endcase
    end

    assign w_wb_data = w_mem_to_reg ? w_dm_rdata : w_alu_result;
    assign w_wb_addr = w_reg_dst_rd ? w_rd : w_rt;

    // ------------------------------------------------------------- next PC
    assign w_pc_plus4      = w_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {w_simm[29:0], 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], w_target, 2'b00};

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_jump) begin
            w_next_pc = w_jump_target;
        end else if (w_branch && (w_rs_data == w_rt_data)) begin
            w_next_pc = w_branch_target;
        end
    end

    assign pc_out    = w_pc;
    assign instr_out = instruction;

endmodule

// -----------------------------------------------------------------------------
// mips_pc: program counter register (current_inst), cleared by reset.
//   clk, i_reset (sync, active high), i_next_pc in, o_pc out
// -----------------------------------------------------------------------------
module mips_pc (
    input  logic        clk,
    input  logic        i_reset,
    input  logic [31:0] i_next_pc,
    output logic [31:0] o_pc
);
    logic [31:0] current_inst;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            current_inst <= '0;
        end else begin
            current_inst <= i_next_pc;
        end
    end

    assign o_pc = current_inst;
endmodule

// -----------------------------------------------------------------------------
// mips_reg_file: 32x32 register file with two combinational read ports and
//   one write port. $0 reads as zero and ignores writes.
//   clk, i_reset, i_rs_addr/i_rt_addr -> o_rs_data/o_rt_data,
//   i_wr_en/i_wr_addr/i_wr_data
// -----------------------------------------------------------------------------
module mips_reg_file (
    input  logic        clk,
    input  logic        i_reset,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);
    logic [31:0] register [0:31];

    // Entry 0 is cleared along with the rest and never written afterwards,
    // so it holds zero for anyone inspecting the array directly.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                register[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != 5'd0)) begin
            register[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rs_data = (i_rs_addr == 5'd0) ? 32'd0 : register[i_rs_addr];
    assign o_rt_data = (i_rt_addr == 5'd0) ? 32'd0 : register[i_rt_addr];
endmodule

// -----------------------------------------------------------------------------
// mips_inst_mem: byte-wide instruction store with a combinational big-endian
//   word read (byte at i_addr lands in bits 31:24). Addresses wrap modulo
//   DEPTH. The byte write port lets a loader fill the array; the core ties it off.
//   clk, i_wr_en/i_wr_addr/i_wr_byte, i_addr -> o_word
// -----------------------------------------------------------------------------
module mips_inst_mem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_addr,
    input  logic [7:0]  i_wr_byte,
    input  logic [31:0] i_addr,
    output logic [31:0] o_word
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    InstructionMemory [0:DEPTH-1];
    logic [AW-1:0] w_byte_idx [0:3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte_idx[gi]       = AW'((i_addr + 32'(gi)) % DEPTH);
            assign o_word[31-8*gi -: 8] = InstructionMemory[w_byte_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            InstructionMemory[AW'(i_wr_addr % DEPTH)] <= i_wr_byte;
        end
    end
endmodule

// -----------------------------------------------------------------------------
// mips_data_mem: byte-wide data store. It has a combinational big-endian word
//   read and a 4-byte big-endian word write on the clock edge. There is no
//   alignment restriction, and every byte address wraps modulo DEPTH.
//   clk, i_wr_en, i_addr, i_wr_data -> o_rd_data
// -----------------------------------------------------------------------------
module mips_data_mem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    data_memory [0:DEPTH-1];
    logic [AW-1:0] w_byte_idx [0:3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte_idx[gi]          = AW'((i_addr + 32'(gi)) % DEPTH);
            assign o_rd_data[31-8*gi -: 8] = data_memory[w_byte_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                data_memory[w_byte_idx[k]] <= i_wr_data[31-8*k -: 8];
            end
        end
    end
endmodule

// File: tb/tb_mips_single_cycle.sv
// -----------------------------------------------------------------------------
// tb_mips_single_cycle
//   The bench runs a directed program and then a set of random programs on
//   mips_single_cycle. A behavioural ISA interpreter (the model) precomputes
//   the expected trace for each run. Each trace entry holds the PC, the
//   instruction, selected registers and memory words, and a digest of the
//   whole architectural state. Entries go into a queue. A monitor pops one
//   entry per cycle and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_mips_single_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    mips_single_cycle #(.IMEM_BYTES(256), .DMEM_BYTES(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_out    (pc_out),
        .instr_out (instr_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ----------------------------------------------------------------- model
    logic [31:0] m_reg [32];
    logic [7:0]  m_dm  [256];
    logic [7:0]  m_im  [256];
    logic [31:0] m_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] r0;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] dm0;
        logic [31:0] dm4;
        logic [31:0] digest;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   run_active = 1'b0;
    int   run_id     = 0;
    int   step_id    = 0;

    function automatic logic [31:0] m_word(input logic [31:0] a, input bit imem);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] idx;
            idx = 8'(a + 32'(k));
            w[31-8*k -: 8] = imem ? m_im[idx] : m_dm[idx];
        end
        return w;
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            m_dm[8'(a + 32'(k))] = v[31-8*k -: 8];
        end
    endfunction

    function automatic void m_set_reg(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] v);
        return (h ^ v) * 32'h0100_0193;
    endfunction

    function automatic logic [31:0] model_digest();
        logic [31:0] h;
        h = 32'h811C_9DC5;
        for (int i = 0; i < 32; i++)  h = mix(h, m_reg[i]);
        for (int i = 0; i < 256; i++) h = mix(h, {24'd0, m_dm[i]});
        return h;
    endfunction

    function automatic logic [31:0] dut_digest();
        logic [31:0] h;
        h = 32'h811C_9DC5;
        for (int i = 0; i < 32; i++)  h = mix(h, dut.register.register[i]);
        for (int i = 0; i < 256; i++) h = mix(h, {24'd0, dut.data_mem.data_memory[i]});
        return h;
    endfunction

    function automatic logic [31:0] dut_dm_word(input int a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[31-8*k -: 8] = dut.data_mem.data_memory[(a + k) % 256];
        return w;
    endfunction

    // One architectural step of the ISA: read operands, apply the rule, commit.
    function automatic void model_step();
        logic [31:0] ins, a, b, simm, pc4, nxt;
        logic [4:0]  rs, rt, rd;
        ins  = m_word(m_pc, 1'b1);
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        a    = m_reg[rs];
        b    = m_reg[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        pc4  = m_pc + 32'd4;
        nxt  = pc4;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: m_set_reg(rd, a + b);
                6'h22: m_set_reg(rd, a - b);
                6'h24: m_set_reg(rd, a & b);
                6'h25: m_set_reg(rd, a | b);
                6'h2A: m_set_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                default: ;
            endcase
            6'h23: m_set_reg(rt, m_word(a + simm, 1'b0));
            6'h2B: m_store(a + simm, b);
            6'h04: if (a == b) nxt = pc4 + (simm << 2);
            6'h08: m_set_reg(rt, a + simm);
            6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = nxt;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.pc     = m_pc;
        e.instr  = m_word(m_pc, 1'b1);
        e.r0     = m_reg[0];
        e.t0     = m_reg[8];
        e.t1     = m_reg[9];
        e.t2     = m_reg[10];
        e.dm0    = m_word(32'd0, 1'b0);
        e.dm4    = m_word(32'd4, 1'b0);
        e.digest = model_digest();
        return e;
    endfunction

    function automatic void put_word(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) m_im[(addr + k) % 256] = w[31-8*k -: 8];
    endfunction

    function automatic logic [31:0] rand_instr();
        int unsigned k;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm, off;
        logic [31:0] w;
        k   = $urandom_range(0, 11);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(1, 7));
        imm = 16'($urandom);
        off = 16'($urandom_range(0, 16)) - 16'd8;
        case (k)
            0: w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1: w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2: w = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            3: w = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4: w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            5: w = {6'h23, rs, rt, imm};
            6: w = {6'h2B, rs, rt, imm};
            7: w = {6'h04, rs, rt, off};
            8: w = {6'h08, rs, rt, imm};
            9: w = {6'h02, 20'd0, 6'($urandom_range(0, 63))};
            10: w = {6'h00, rs, rt, rd, 5'd0, 6'h21};   // R-type funct outside the supported set, acts as NOP
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s run %0d step %0d: got %08h expected %08h", name, run_id, step_id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_active) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty run %0d step %0d: got no expectation, required one", run_id, step_id);
            end else begin
                mon_e = exp_q.pop_front();
                check("pc_out",    pc_out,                     mon_e.pc);
                check("instr_out", instr_out,                  mon_e.instr);
                check("reg0",      dut.register.register[0],   mon_e.r0);
                check("reg_t0",    dut.register.register[8],   mon_e.t0);
                check("reg_t1",    dut.register.register[9],   mon_e.t1);
                check("reg_t2",    dut.register.register[10],  mon_e.t2);
                check("dm_word0",  dut_dm_word(0),             mon_e.dm0);
                check("dm_word4",  dut_dm_word(4),             mon_e.dm4);
                check("state_digest", dut_digest(),            mon_e.digest);
                $display("run %0d step %0d pc=%08h instr=%08h t0=%08h t1=%08h t2=%08h dm0=%08h",
                         run_id, step_id, pc_out, instr_out, mon_e.t0, mon_e.t1, mon_e.t2, mon_e.dm0);
            end
            step_id++;
        end
    end

    // ------------------------------------------------------------- stimulus
    // Reset must already be high on entry; the IM in the model is copied into
    // the DUT here while reset holds off any store.
    task automatic run_program(input int n_instr);
        for (int i = 0; i < 256; i++) dut.inst_mem.InstructionMemory[i] = m_im[i];
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pc = 32'd0;
        for (int k = 0; k <= n_instr; k++) begin
            exp_q.push_back(snapshot());
            if (k < n_instr) model_step();
        end
        step_id = 0;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        run_active = 1'b1;
        repeat (n_instr) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_active = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain run %0d: got %0d entries left, required 0", run_id, exp_q.size());
            exp_q.delete();
        end
        run_id++;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m_dm[i] = 8'($urandom);
            m_im[i] = 8'd0;
        end
        m_store(32'd0, 32'h0000_0010);
        m_store(32'd4, 32'h0000_0005);
        for (int i = 0; i < 256; i++) dut.data_mem.data_memory[i] = m_dm[i];

        // Directed program
        put_word(32'h00, 32'h8C08_0000);   // lw   $t0, 0($0)
        put_word(32'h04, 32'h8C09_0004);   // lw   $t1, 4($0)
        put_word(32'h08, 32'h0128_5020);   // add  $t2, $t1, $t0
        put_word(32'h0C, 32'h0148_5022);   // sub  $t2, $t2, $t0
        put_word(32'h10, 32'hAC0A_0000);   // sw   $t2, 0($0)
        put_word(32'h14, 32'h114A_0004);   // beq  $t2, $t2, +4 -> 0x28
        put_word(32'h18, 32'h2108_0001);   // skipped
        put_word(32'h1C, 32'h2108_0001);   // skipped
        put_word(32'h20, 32'h2108_0001);   // skipped
        put_word(32'h24, 32'h2108_0001);   // skipped
        put_word(32'h28, 32'h0129_4820);   // add  $t1, $t1, $t1
        put_word(32'h2C, 32'h2000_0007);   // addi $0, $0, 7
        put_word(32'h30, 32'hFC00_0000);   // undefined opcode
        put_word(32'h34, 32'h0800_0010);   // j    0x40
        put_word(32'h38, 32'h2108_0001);   // skipped
        put_word(32'h40, 32'h2008_FFFF);   // addi $t0, $0, -1
        put_word(32'h44, 32'h0109_502A);   // slt  $t2, $t0, $t1
        put_word(32'h48, 32'h0109_5024);   // and  $t2, $t0, $t1
        put_word(32'h4C, 32'h0109_5025);   // or   $t2, $t0, $t1
        put_word(32'h50, 32'h1109_FFFB);   // beq  $t0, $t1 (not taken)
        put_word(32'h54, 32'h0800_0000);   // j    0x00
        run_program(40);

        // Random programs; word 0 is a store so reset overlapping it is exercised.
        repeat (6) begin
            for (int w = 0; w < 64; w++) begin
                put_word(4 * w, (w == 0) ? 32'hAC41_0000 : rand_instr());
            end
            run_program(80);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
